// File: rtl/data_mem_responder.sv
// Memory-side responder for MEM-stage loads/stores: byte-lane steering on stores,
// right-justified load data, BUSYWAIT stall. Define MISALIGN_TRAP_EN to refuse misaligned H/W.
module data_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [31:0] ADDRESS,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] WRITEDATA,
    output logic [31:0] READDATA,
    output logic        BUSYWAIT,
`ifdef MISALIGN_TRAP_EN
    output logic        MISALIGNED,
`endif
    output logic [1:0]  dbg_state_o
);
    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  is_write_q, is_write_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           mem_q [WORDS];

    logic                  legal, req_ok, accept, commit;
    logic [ADDR_WIDTH-3:0] widx;
    logic [31:0]           word, load_data, wlanes;
    logic [3:0]            be;
    logic                  busy;
    logic                  unused_addr_bits;

    assign unused_addr_bits = ^ADDRESS[31:ADDR_WIDTH];

    always_comb begin
        legal = 1'b0;
        case (FUNCT3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = READ;
            default:                legal = 1'b0;
        endcase
    end

    assign req_ok = (READ ^ WRITE) & legal;

`ifdef MISALIGN_TRAP_EN
    logic misaligned, misaligned_q;
    assign misaligned = ((FUNCT3[1:0] == 2'b01) & ADDRESS[0]) |
                        ((FUNCT3[1:0] == 2'b10) & (|ADDRESS[1:0]));
    assign accept     = req_ok & ~misaligned;
    assign MISALIGNED = misaligned_q;

    always_ff @(posedge CLK) begin
        if (RESET) misaligned_q <= 1'b0;
        else       misaligned_q <= (state_q == IDLE) & req_ok & misaligned;
    end
`else
    assign accept = req_ok;
`endif

    assign widx   = addr_q[ADDR_WIDTH-1:2];
    assign word   = mem_q[widx];
    assign commit = (state_q == ACCESS) && (cnt_q == '0);

    always_comb begin
        load_data = word;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0:    load_data = {24'b0, word[7:0]};
                    2'd1:    load_data = {24'b0, word[15:8]};
                    2'd2:    load_data = {24'b0, word[23:16]};
                    default: load_data = {24'b0, word[31:24]};
                endcase
            end
            2'b01:   load_data = {16'b0, (addr_q[1] ? word[31:16] : word[15:0])};
            default: load_data = word;
        endcase
    end

    // Replicate the store data across lanes; the byte enables pick which lanes land.
    always_comb begin
        be     = 4'b1111;
        wlanes = wdata_q;
        case (size_q)
            2'b00: begin
                be     = 4'b0001 << addr_q[1:0];
                wlanes = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be     = addr_q[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata_q[15:0]}};
            end
            default: begin
                be     = 4'b1111;
                wlanes = wdata_q;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET && commit && is_write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[widx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    // Handshake: a request is taken in IDLE on the edge where BUSYWAIT is high; the
    // pipeline holds its request while BUSYWAIT=1 and advances on the DONE edge (BUSYWAIT=0).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        rdata_d    = rdata_q;
        busy       = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    busy       = 1'b1;
                    state_d    = ACCESS;
                    cnt_d      = CNT_LOAD;
                    addr_d     = ADDRESS[ADDR_WIDTH-1:0];
                    size_d     = FUNCT3[1:0];
                    wdata_d    = WRITEDATA;
                    is_write_d = WRITE;
                end
            end
            ACCESS: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (!is_write_q) rdata_d = load_data;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            size_q     <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            rdata_q    <= rdata_d;
        end
    end

    assign READDATA    = rdata_q;
    assign BUSYWAIT    = busy;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder (LATENCY=5, ADDR_WIDTH=10).
module tb_data_mem_responder;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        READ;
    logic        WRITE;
    logic [31:0] ADDRESS;
    logic [2:0]  FUNCT3;
    logic [31:0] WRITEDATA;
    logic [31:0] READDATA;
    logic        BUSYWAIT;
    logic [1:0]  dbg_state;
`ifdef MISALIGN_TRAP_EN
    logic        MISALIGNED;
`endif

    localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010,
                           F_BU = 3'b100, F_HU = 3'b101;

    int n_checks = 0;
    int n_pass   = 0;

    data_mem_responder #(.ADDR_WIDTH(10), .LATENCY(5)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .READ       (READ),
        .WRITE      (WRITE),
        .ADDRESS    (ADDRESS),
        .FUNCT3     (FUNCT3),
        .WRITEDATA  (WRITEDATA),
        .READDATA   (READDATA),
        .BUSYWAIT   (BUSYWAIT),
`ifdef MISALIGN_TRAP_EN
        .MISALIGNED (MISALIGNED),
`endif
        .dbg_state_o(dbg_state)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    endtask

    // Applies a request in an IDLE cycle and holds it until BUSYWAIT drops (DONE or refused).
    task automatic xfer(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int exp_busy, input logic [31:0] exp_rd);
        int busy = 0;
        bit done = 1'b0;
        @(negedge CLK);
        READ = rd; WRITE = wr; FUNCT3 = f3; ADDRESS = addr; WRITEDATA = wd;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (BUSYWAIT) begin
                busy++;
                @(negedge CLK);
            end else begin
                done = 1'b1;
            end
        end
        if (!done) check({tag, " stuck"}, {31'b0, BUSYWAIT}, 32'd0);
        check({tag, " busy"}, 32'(busy), 32'(exp_busy));
        check({tag, " data"}, READDATA, exp_rd);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET = 1'b1; READ = 1'b0; WRITE = 1'b0;
        FUNCT3 = 3'b000; ADDRESS = '0; WRITEDATA = '0;
        repeat (2) @(negedge CLK);
        #1;
        check("rst busy", {31'b0, BUSYWAIT}, 32'd0);
        check("rst data", READDATA, 32'd0);
        check("rst state", {30'b0, dbg_state}, 32'd0);
        RESET = 1'b0;

        xfer("sw 010",  1'b0, 1'b1, F_W,  32'h010, 32'hDEADBEEF, 6, 32'h0);
        xfer("lw 010",  1'b1, 1'b0, F_W,  32'h010, 32'h0,        6, 32'hDEADBEEF);
        xfer("sb 013",  1'b0, 1'b1, F_B,  32'h013, 32'hFFFFFF5A, 6, 32'hDEADBEEF);
        xfer("lw 010b", 1'b1, 1'b0, F_W,  32'h010, 32'h0,        6, 32'h5AADBEEF);
        xfer("lbu 013", 1'b1, 1'b0, F_BU, 32'h013, 32'h0,        6, 32'h0000005A);
        xfer("lhu 012", 1'b1, 1'b0, F_HU, 32'h012, 32'h0,        6, 32'h00005AAD);
        xfer("lb 010",  1'b1, 1'b0, F_B,  32'h010, 32'h0,        6, 32'h000000EF);
        xfer("lh 010",  1'b1, 1'b0, F_H,  32'h010, 32'h0,        6, 32'h0000BEEF);

        xfer("sw 020",  1'b0, 1'b1, F_W,  32'h020, 32'h0,        6, 32'h0000BEEF);
        xfer("sh 022",  1'b0, 1'b1, F_H,  32'h022, 32'hABCD1234, 6, 32'h0000BEEF);
        xfer("lw 020",  1'b1, 1'b0, F_W,  32'h020, 32'h0,        6, 32'h12340000);
        xfer("lh 022",  1'b1, 1'b0, F_H,  32'h022, 32'h0,        6, 32'h00001234);
        xfer("sb 021",  1'b0, 1'b1, F_B,  32'h021, 32'h00000077, 6, 32'h00001234);
        xfer("lbu 021", 1'b1, 1'b0, F_BU, 32'h021, 32'h0,        6, 32'h00000077);
        xfer("lw 020b", 1'b1, 1'b0, F_W,  32'h020, 32'h0,        6, 32'h12347700);

        xfer("ill rw",  1'b1, 1'b1, F_W,    32'h010, 32'h0,      0, 32'h12347700);
        xfer("ill f3r", 1'b1, 1'b0, 3'b011, 32'h010, 32'h0,      0, 32'h12347700);
        xfer("ill f3w", 1'b0, 1'b1, F_BU,   32'h010, 32'h0,      0, 32'h12347700);
        xfer("ill none",1'b0, 1'b0, F_W,    32'h010, 32'h0,      0, 32'h12347700);
        xfer("lw after",1'b1, 1'b0, F_W,    32'h010, 32'h0,      6, 32'h5AADBEEF);

        xfer("wrap 410", 1'b1, 1'b0, F_W, 32'h00000410, 32'h0, 6, 32'h5AADBEEF);
        xfer("wrap hi",  1'b1, 1'b0, F_W, 32'hFFFFFC10, 32'h0, 6, 32'h5AADBEEF);

`ifdef MISALIGN_TRAP_EN
        @(negedge CLK);
        READ = 1'b1; WRITE = 1'b0; FUNCT3 = F_W; ADDRESS = 32'h011;
        #1;
        check("trap busy", {31'b0, BUSYWAIT}, 32'd0);
        @(negedge CLK);
        READ = 1'b0;
        #1;
        check("trap pulse", {31'b0, MISALIGNED}, 32'd1);
        check("trap busy2", {31'b0, BUSYWAIT}, 32'd0);
        @(negedge CLK);
        #1;
        check("trap end", {31'b0, MISALIGNED}, 32'd0);
        check("trap data", READDATA, 32'h5AADBEEF);
`else
        xfer("mis lw 011", 1'b1, 1'b0, F_W, 32'h011, 32'h0, 6, 32'h5AADBEEF);
        xfer("mis lh 023", 1'b1, 1'b0, F_H, 32'h023, 32'h0, 6, 32'h00001234);
`endif
        xfer("lw resync", 1'b1, 1'b0, F_W, 32'h010, 32'h0, 6, 32'h5AADBEEF);

        xfer("sw 030", 1'b0, 1'b1, F_W, 32'h030, 32'h11111111, 6, 32'h5AADBEEF);
        @(negedge CLK);
        READ = 1'b0; WRITE = 1'b1; FUNCT3 = F_W; ADDRESS = 32'h030; WRITEDATA = 32'hFFFFFFFF;
        @(negedge CLK);
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("mid state", {30'b0, dbg_state}, 32'd1);
        check("mid busy", {31'b0, BUSYWAIT}, 32'd1);
        RESET = 1'b1;
        WRITE = 1'b0;
        @(negedge CLK);
        #1;
        check("abort busy", {31'b0, BUSYWAIT}, 32'd0);
        check("abort data", READDATA, 32'd0);
        check("abort state", {30'b0, dbg_state}, 32'd0);
        RESET = 1'b0;
        xfer("lw 030", 1'b1, 1'b0, F_W, 32'h030, 32'h0, 6, 32'h11111111);

        xfer("b2b lw 010", 1'b1, 1'b0, F_W, 32'h010, 32'h0, 6, 32'h5AADBEEF);
        xfer("b2b lw 020", 1'b1, 1'b0, F_W, 32'h020, 32'h0, 6, 32'h12347700);

        @(negedge CLK);
        READ = 1'b0; WRITE = 1'b0;
        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
